// File: rtl/mesh_term_port_if.sv
// Host-side and mesh-side signals of one mesh terminal port.
// The slave modport is the port block; the master modport is the host plus mesh environment.
interface mesh_term_port_if #(
   parameter int pckg_sz = 40,
   parameter int cnt_w   = 16
);
   logic               tx_push;
   logic [pckg_sz-1:0] tx_data;
   logic               tx_full;
   logic [pckg_sz-1:0] data_out_i_in;
   logic               pndng_i_in;
   logic               popin;
   logic               pndng;
   logic [pckg_sz-1:0] data_out;
   logic               pop;
   logic               rx_pop;
   logic [pckg_sz-1:0] rx_data;
   logic               rx_empty;
   logic               misroute;
   logic [cnt_w-1:0]   tx_cnt;
   logic [cnt_w-1:0]   rx_cnt;

   modport slave (
      input  tx_push, tx_data, popin, pndng, data_out, rx_pop,
      output tx_full, data_out_i_in, pndng_i_in, pop, rx_data, rx_empty, misroute,
             tx_cnt, rx_cnt
   );

   modport master (
      output tx_push, tx_data, popin, pndng, data_out, rx_pop,
      input  tx_full, data_out_i_in, pndng_i_in, pop, rx_data, rx_empty, misroute,
             tx_cnt, rx_cnt
   );
endinterface

// File: rtl/mesh_term_port.sv
// Mesh terminal endpoint: TX FIFO with source stamping towards the mesh, RX FIFO fed by a pop/wait FSM.
// One-cycle write-to-head latency on both FIFOs; a full RX FIFO holds packets back in the mesh.

module mesh_term_fifo #(
   parameter int width = 40,
   parameter int depth = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [width-1:0] wr_dat,
   input  logic             rd,
   output logic [width-1:0] head,
   output logic             full,
   output logic             empty,
   output logic             avail
);
   localparam int aw = (depth > 1) ? $clog2(depth) : 1;
   localparam int cw = aw + 1;

   logic [width-1:0] mem [depth];
   logic [aw-1:0]    rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n;
   logic [cw-1:0]    count, count_n;
   logic             do_wr, do_rd;

   function automatic logic [aw-1:0] ptr_inc(input logic [aw-1:0] p);
      return (p == aw'(depth - 1)) ? '0 : p + aw'(1);
   endfunction

   assign do_wr = wr && !full;
   assign do_rd = rd && !empty;

   always_comb begin
      rd_ptr_n = do_rd ? ptr_inc(rd_ptr) : rd_ptr;
      wr_ptr_n = do_wr ? ptr_inc(wr_ptr) : wr_ptr;
      count_n  = count;
      if (do_wr && !do_rd)
         count_n = count + cw'(1);
      else if (!do_wr && do_rd)
         count_n = count - cw'(1);
   end

   always_ff @(posedge clk) begin
      if (do_wr)
         mem[wr_ptr] <= wr_dat;
   end

   // Head and flags are registered from next-state values so every output is a flop.
   // The bypass covers a write landing in the slot that becomes the head.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         head   <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         avail  <= 1'b0;
      end else begin
         rd_ptr <= rd_ptr_n;
         wr_ptr <= wr_ptr_n;
         count  <= count_n;
         full   <= (count_n == cw'(depth));
         empty  <= (count_n == '0);
         avail  <= (count_n != '0);
         if (do_wr && (wr_ptr == rd_ptr_n))
            head <= wr_dat;
         else
            head <= mem[rd_ptr_n];
      end
   end
endmodule

module mesh_term_port #(
   parameter int         pckg_sz    = 40,
   parameter int         fifo_depth = 4,
   parameter logic [3:0] id_r       = 4'd0,
   parameter logic [3:0] id_c       = 4'd0,
   parameter int         cnt_w      = 16
) (
   input  logic             clk,
   input  logic             rst,
   mesh_term_port_if.slave  port
);
   localparam logic [7:0] own_id = {id_r, id_c};

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } rx_state_t;

   rx_state_t          state, state_n;
   logic               capture;
   logic [pckg_sz-1:0] tx_stamped;
   logic               tx_empty;
   logic               tx_take;
   logic               rx_full;
   logic               rx_avail;
   logic               rx_take;

   always_comb begin
      tx_stamped                  = port.tx_data;
      tx_stamped[pckg_sz-9 -: 8]  = own_id;
   end

   assign tx_take = port.popin && !tx_empty;
   assign rx_take = port.rx_pop && rx_avail;

   mesh_term_fifo #(
      .width (pckg_sz),
      .depth (fifo_depth)
   ) u_tx_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr     (port.tx_push),
      .wr_dat (tx_stamped),
      .rd     (tx_take),
      .head   (port.data_out_i_in),
      .full   (port.tx_full),
      .empty  (tx_empty),
      .avail  (port.pndng_i_in)
   );

   mesh_term_fifo #(
      .width (pckg_sz),
      .depth (fifo_depth)
   ) u_rx_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr     (capture),
      .wr_dat (port.data_out),
      .rd     (rx_take),
      .head   (port.rx_data),
      .full   (rx_full),
      .empty  (port.rx_empty),
      .avail  (rx_avail)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_n;
   end

   // The mesh's pndng is registered, so after each pop one cycle is spent waiting for it to update.
   always_comb begin
      state_n = state;
      capture = 1'b0;
      case (state)
         S_IDLE: begin
            if (port.pndng && !rx_full) begin
               capture = 1'b1;
               state_n = S_WAIT;
            end
         end
         S_WAIT:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         port.pop      <= 1'b0;
         port.misroute <= 1'b0;
         port.tx_cnt   <= '0;
         port.rx_cnt   <= '0;
      end else begin
         port.pop      <= capture;
         port.misroute <= capture && (port.data_out[pckg_sz-1 -: 8] != own_id);
         if (capture)
            port.rx_cnt <= port.rx_cnt + cnt_w'(1);
         if (tx_take)
            port.tx_cnt <= port.tx_cnt + cnt_w'(1);
      end
   end
endmodule

// File: tb/tb_mesh_term_port.sv
// Directed bench for mesh_term_port at node (1,2): a mesh model feeds the RX side, queues hold expected packets.
module tb_mesh_term_port;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   mis_cnt = 0;

   logic [39:0] tx_q[$];
   logic [39:0] rx_q[$];
   logic [39:0] mesh_q[$];
   int          pop_times[$];

   mesh_term_port_if #(.pckg_sz(40), .cnt_w(16)) bus ();

   mesh_term_port #(
      .pckg_sz    (40),
      .fifo_depth (4),
      .id_r       (4'd1),
      .id_c       (4'd2),
      .cnt_w      (16)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .port (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_pndng_i_in"}, 64'(bus.pndng_i_in), 0);
      chk({tag, "_data_out_i_in"}, 64'(bus.data_out_i_in), 0);
      chk({tag, "_tx_full"}, 64'(bus.tx_full), 0);
      chk({tag, "_pop"}, 64'(bus.pop), 0);
      chk({tag, "_rx_empty"}, 64'(bus.rx_empty), 1);
      chk({tag, "_rx_data"}, 64'(bus.rx_data), 0);
      chk({tag, "_misroute"}, 64'(bus.misroute), 0);
      chk({tag, "_tx_cnt"}, 64'(bus.tx_cnt), 0);
      chk({tag, "_rx_cnt"}, 64'(bus.rx_cnt), 0);
   endtask

   // Mesh model: pndng updates one cycle after a pop, data_out shows the queue head.
   initial begin : mesh_model
      bit pend;
      bus.pndng    = 1'b0;
      bus.data_out = '0;
      forever begin
         @(negedge clk);
         pend = bus.pop;
         if (bus.misroute) mis_cnt++;
         if (bus.pop) begin
            pop_times.push_back(cyc);
            if (mesh_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pop_on_empty_mesh actual=1 required=0");
            end else begin
               chk("misroute_at_pop", 64'(bus.misroute), 64'(mesh_q[0][39:32] != 8'h12));
            end
         end else if (bus.misroute) begin
            checks++;
            errors++;
            $display("FAIL misroute_without_pop actual=1 required=0");
         end
         @(posedge clk);
         #2;
         if (pend && mesh_q.size() > 0) void'(mesh_q.pop_front());
         bus.pndng    = (mesh_q.size() > 0);
         bus.data_out = (mesh_q.size() > 0) ? mesh_q[0] : '0;
      end
   end

   // Scoreboard monitor: compares each packet the DUT hands over against the queues.
   always @(negedge clk) begin
      if (bus.popin && bus.pndng_i_in) begin
         if (tx_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected actual=%0h required=none", bus.data_out_i_in);
         end else begin
            chk("tx_packet", 64'(bus.data_out_i_in), 64'(tx_q.pop_front()));
         end
      end
      if (bus.rx_pop && !bus.rx_empty) begin
         if (rx_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected actual=%0h required=none", bus.rx_data);
         end else begin
            chk("rx_packet", 64'(bus.rx_data), 64'(rx_q.pop_front()));
         end
      end
   end

   initial begin
      rst         = 1'b1;
      bus.tx_push = 1'b0;
      bus.tx_data = '0;
      bus.popin   = 1'b0;
      bus.rx_pop  = 1'b0;
      repeat (2) @(posedge clk);
      sample();
      check_reset("reset");
      step();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         sample();
         chk("idle_pop", 64'(bus.pop), 0);
         chk("idle_pndng_i_in", 64'(bus.pndng_i_in), 0);
      end
      step();

      // Single packet: source byte stamped with 8'h12, one-cycle latency.
      bus.tx_push = 1'b1;
      bus.tx_data = 40'h12FF00000A;
      tx_q.push_back(40'h121200000A);
      step();
      bus.tx_push = 1'b0;
      sample();
      chk("tx_first_pndng", 64'(bus.pndng_i_in), 1);
      chk("tx_first_data", 64'(bus.data_out_i_in), 64'h121200000A);
      step();
      bus.popin = 1'b1;
      step();
      bus.popin = 1'b0;
      sample();
      chk("tx_after_pop_pndng", 64'(bus.pndng_i_in), 0);
      chk("tx_cnt_1", 64'(bus.tx_cnt), 1);
      step();

      // Five pushes into a 4-deep FIFO: fifth dropped.
      for (int i = 1; i <= 5; i++) begin
         bus.tx_push = 1'b1;
         bus.tx_data = {8'h34, 8'hAA, 24'(i)};
         if (i <= 4) tx_q.push_back({8'h34, 8'h12, 24'(i)});
         step();
      end
      bus.tx_push = 1'b0;
      sample();
      chk("tx_full", 64'(bus.tx_full), 1);
      chk("tx_full_head", 64'(bus.data_out_i_in), 64'h3412000001);
      step();
      bus.popin = 1'b1;
      repeat (4) step();
      bus.popin = 1'b0;
      sample();
      chk("tx_cnt_5", 64'(bus.tx_cnt), 5);
      chk("tx_drained_pndng", 64'(bus.pndng_i_in), 0);
      chk("tx_drained_full", 64'(bus.tx_full), 0);
      step();
      bus.popin = 1'b1;
      step();
      bus.popin = 1'b0;
      sample();
      chk("tx_popin_empty_cnt", 64'(bus.tx_cnt), 5);
      step();

      // Push and pop in the same cycle.
      bus.tx_push = 1'b1;
      bus.tx_data = 40'h56000000AA;
      tx_q.push_back(40'h56120000AA);
      step();
      bus.tx_data = 40'h56000000BB;
      tx_q.push_back(40'h56120000BB);
      bus.popin = 1'b1;
      step();
      bus.tx_push = 1'b0;
      bus.popin   = 1'b0;
      sample();
      chk("tx_pushpop_pndng", 64'(bus.pndng_i_in), 1);
      chk("tx_pushpop_head", 64'(bus.data_out_i_in), 64'h56120000BB);
      chk("tx_pushpop_cnt", 64'(bus.tx_cnt), 6);
      step();
      bus.popin = 1'b1;
      step();
      bus.popin = 1'b0;
      sample();
      chk("tx_cnt_7", 64'(bus.tx_cnt), 7);
      step();

      // Three packets for this node: pops every second cycle.
      pop_times.delete();
      for (int i = 0; i < 3; i++) begin
         mesh_q.push_back({8'h12, 8'h77, 24'(32'h100 + i)});
         rx_q.push_back({8'h12, 8'h77, 24'(32'h100 + i)});
      end
      repeat (10) step();
      sample();
      chk("rx3_pop_count", 64'(pop_times.size()), 3);
      if (pop_times.size() == 3) begin
         chk("rx3_gap1", 64'(pop_times[1] - pop_times[0]), 2);
         chk("rx3_gap2", 64'(pop_times[2] - pop_times[1]), 2);
      end
      chk("rx3_cnt", 64'(bus.rx_cnt), 3);
      chk("rx3_head", 64'(bus.rx_data), 64'h1277000100);
      chk("rx3_mis_cnt", 64'(mis_cnt), 0);
      step();
      bus.rx_pop = 1'b1;
      repeat (3) step();
      bus.rx_pop = 1'b0;
      sample();
      chk("rx3_empty", 64'(bus.rx_empty), 1);
      step();

      // RX backpressure: four captured, fifth waits for one host read.
      pop_times.delete();
      for (int i = 0; i < 5; i++) begin
         mesh_q.push_back({8'h12, 8'h88, 24'(i)});
         rx_q.push_back({8'h12, 8'h88, 24'(i)});
      end
      repeat (16) step();
      sample();
      chk("rxbp_pop_count", 64'(pop_times.size()), 4);
      chk("rxbp_mesh_left", 64'(mesh_q.size()), 1);
      chk("rxbp_cnt", 64'(bus.rx_cnt), 7);
      step();
      bus.rx_pop = 1'b1;
      step();
      bus.rx_pop = 1'b0;
      repeat (6) step();
      sample();
      chk("rxbp_pop_count2", 64'(pop_times.size()), 5);
      chk("rxbp_mesh_left2", 64'(mesh_q.size()), 0);
      chk("rxbp_cnt2", 64'(bus.rx_cnt), 8);
      step();
      bus.rx_pop = 1'b1;
      repeat (4) step();
      bus.rx_pop = 1'b0;
      sample();
      chk("rxbp_empty", 64'(bus.rx_empty), 1);
      step();

      // Misrouted packet: flagged for one cycle and still stored.
      mesh_q.push_back(40'h2345ABCDEF);
      rx_q.push_back(40'h2345ABCDEF);
      repeat (5) step();
      sample();
      chk("mis_pulses", 64'(mis_cnt), 1);
      chk("mis_rx_cnt", 64'(bus.rx_cnt), 9);
      chk("mis_stored", 64'(bus.rx_data), 64'h2345ABCDEF);
      step();
      bus.rx_pop = 1'b1;
      step();
      bus.rx_pop = 1'b0;

      // Asynchronous reset with two packets in each FIFO.
      for (int i = 0; i < 2; i++) begin
         bus.tx_push = 1'b1;
         bus.tx_data = {8'h99, 8'h00, 24'(i)};
         mesh_q.push_back({8'h12, 8'h99, 24'(i)});
         step();
      end
      bus.tx_push = 1'b0;
      repeat (8) step();
      sample();
      chk("pre_rst_rx_cnt", 64'(bus.rx_cnt), 11);
      chk("pre_rst_pndng_i_in", 64'(bus.pndng_i_in), 1);
      chk("pre_rst_rx_empty", 64'(bus.rx_empty), 0);
      @(posedge clk);
      #3 rst = 1'b1;
      #1 check_reset("async_rst");
      mesh_q.delete();
      step();
      rst = 1'b0;
      sample();
      check_reset("post_rst");
      step();
      bus.tx_push = 1'b1;
      bus.tx_data = 40'h21000000CC;
      tx_q.push_back(40'h21120000CC);
      step();
      bus.tx_push = 1'b0;
      bus.popin   = 1'b1;
      step();
      bus.popin = 1'b0;
      sample();
      chk("post_rst_tx_cnt", 64'(bus.tx_cnt), 1);
      chk("tx_q_drained", 64'(tx_q.size()), 0);
      chk("rx_q_drained", 64'(rx_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
